int_reg_file64: RTL and testbench
=================================

Name: int_reg_file64

Overview:
- Integer register file on the operand side of the 64-bit ALU.
- Supplies the ALU's R and S operands from two combinational read ports and captures the ALU result Y through one synchronous write port.
- Also holds the architectural status register: the N, Z, C and V flags latched from the ALU.
- Sits between instruction decode and the ALU, closing the datapath loop ALU Y -> write port -> R/S.

Parameters:
- DATA_W, 64, width of each register and of every data port
- NUM_REGS, 32, number of registers; must be a power of two
- ADDR_W, 5, address width; must equal log2(NUM_REGS)
- ZERO_REG, 1, when 1 register 0 always reads zero and ignores writes
- BYPASS, 1, when 1 a same-cycle write is forwarded to the read ports

Ports:
- clk  in  1  single clock, rising-edge
- reset_n  in  1  asynchronous, active-low reset
- W_En  in  1  write enable for the register array
- W_Addr  in  ADDR_W  write address
- WR  in  DATA_W  write data (ALU Y)
- R_Addr  in  ADDR_W  read address, port R
- S_Addr  in  ADDR_W  read address, port S
- R  out  DATA_W  read data to ALU R input
- S  out  DATA_W  read data to ALU S input
- Flag_Ld  in  1  load enable for the status register
- N_in, Z_in, C_in, V_in  in  1 each  ALU flags
- N, Z, C, V  out  1 each  registered status flags
- Wr_Zero_Err  out  1  sticky flag: a write to register 0 was attempted while ZERO_REG=1

Behaviour:
- Reset (reset_n low, asynchronous):
  - all NUM_REGS registers clear to 0
  - N, Z, C, V clear to 0
  - Wr_Zero_Err clears to 0
  - reset takes effect immediately, independent of clk; all writes are blocked while reset_n is low
- Write:
  - on the rising clk edge with W_En=1, reg[W_Addr] <= WR
  - write latency is 1 cycle
  - W_Addr takes only values 0..NUM_REGS-1, so there is no out-of-range case
- Register 0 with ZERO_REG=1:
  - reg[0] is never updated and reads as 0
  - a write attempt sets Wr_Zero_Err=1, which stays set until reset
- Read:
  - combinational: R = reg[R_Addr], S = reg[S_Addr]
  - both ports may address the same register; both then return the same value
- Bypass with BYPASS=1:
  - if W_En=1 and W_Addr==R_Addr, R = WR in the same cycle; S likewise
  - with ZERO_REG=1, address 0 is never bypassed and still reads 0
- Bypass with BYPASS=0: reads return the pre-edge stored value and see a new value the cycle after the write.
- Status register:
  - on the rising clk edge with Flag_Ld=1, {N,Z,C,V} <= {N_in,Z_in,C_in,V_in}
  - otherwise the flags hold their value
  - the flags are independent of W_En; both loads may occur in the same cycle
- Reset released mid-operation: the first rising edge after reset_n goes high performs a normal write or flag load if W_En or Flag_Ld is asserted. The array holds no partial state.
- Simultaneous events: a write and two reads of the same address in one cycle follow the bypass rule; there are no other hazards.
- Width rule: no arithmetic is performed; data passes through at full DATA_W.

Decomposition:
- Shared package alu_pkg holds:
  - DATA_W
  - the ALU opcode constants (5-bit ops 00000..11000)
  - the flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
- One natural sub-module, status_flag_reg: the 4-bit enabled flag register with asynchronous active-low clear, reusable for the future shifter-flag (SOR/SOL) latch.
- The register array and bypass muxes stay in int_reg_file64.

Test Plan:
- Reset: hold reset_n=0, then release; read all 32 addresses on R and S -> all read 64'h0; N=Z=C=V=0; Wr_Zero_Err=0.
- Write then read: W_En=1, W_Addr=5, WR=64'h0123_4567_89AB_CDEF. Next cycle R_Addr=5, S_Addr=5 -> R=S=64'h0123_4567_89AB_CDEF. R_Addr=6 -> R=0.
- Bypass: in the same cycle, W_En=1, W_Addr=7, WR=64'hFFFF_FFFF_FFFF_FFFF, R_Addr=7 -> R=64'hFFFF_FFFF_FFFF_FFFF before the clock edge. Repeat with BYPASS=0 -> R=0 until after the edge.
- Zero register: W_En=1, W_Addr=0, WR=64'hDEAD_BEEF -> R_Addr=0 reads 0, and the same-cycle bypass also reads 0; Wr_Zero_Err=1 from the next edge and stays 1 over 10 cycles.
- Flags: Flag_Ld=1 with {N_in,Z_in,C_in,V_in}=4'b1011 -> {N,Z,C,V}=4'b1011 after the edge. Flag_Ld=0 with inputs 4'b0100 for 3 cycles -> flags hold 4'b1011.
- Asynchronous reset mid-operation: load reg[3]=64'h5 and flags=4'b1111. Pull reset_n low between clock edges -> R(addr 3)=0 and flags=0 immediately, without waiting for a clock edge. Release reset_n and write reg[3]=64'h9 -> reads 64'h9 on the next cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the 64-bit ALU datapath.
//   DATA_W      - datapath width used by the ALU and its register file
//   alu_op_e    - 5-bit ALU opcodes 5'b00000..5'b11000
//   FLAG_*      - bit positions of N/Z/C/V inside a packed 4-bit flag vector
package alu_pkg;

  localparam int DATA_W = 64;

  typedef enum logic [4:0] {
    OP_ADD   = 5'b00000,
    OP_ADDC  = 5'b00001,
    OP_SUB   = 5'b00010,
    OP_SUBC  = 5'b00011,
    OP_SUBR  = 5'b00100,
    OP_SUBRC = 5'b00101,
    OP_AND   = 5'b00110,
    OP_OR    = 5'b00111,
    OP_XOR   = 5'b01000,
    OP_NAND  = 5'b01001,
    OP_NOR   = 5'b01010,
    OP_XNOR  = 5'b01011,
    OP_NOTR  = 5'b01100,
    OP_PASSR = 5'b01101,
    OP_PASSS = 5'b01110,
    OP_INC   = 5'b01111,
    OP_DEC   = 5'b10000,
    OP_SHL   = 5'b10001,
    OP_SHR   = 5'b10010,
    OP_SAR   = 5'b10011,
    OP_ROL   = 5'b10100,
    OP_ROR   = 5'b10101,
    OP_SOL   = 5'b10110,
    OP_SOR   = 5'b10111,
    OP_ZERO  = 5'b11000
  } alu_op_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/status_flag_reg.sv
// Enabled flag register with asynchronous active-low clear.
// Ports:
//   clk      - rising-edge clock
//   rst_n    - asynchronous active-low clear
//   i_ld     - load enable; register holds when low
//   i_d      - flag inputs (packed, FLAG_* ordering for ALU status)
//   o_q      - registered flags
module status_flag_reg
  import alu_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_ld,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_ld) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/int_reg_file64.sv
// Integer register file feeding the ALU R/S operands and capturing ALU Y.
// Ports:
//   clk, reset_n          - clock and asynchronous active-low reset
//   W_En, W_Addr, WR      - synchronous write port (1-cycle latency)
//   R_Addr/R, S_Addr/S    - two combinational read ports
//   Flag_Ld, N/Z/C/V_in   - status register load
//   N, Z, C, V            - registered status flags
//   Wr_Zero_Err           - sticky: write to register 0 attempted (ZERO_REG=1)
// With BYPASS=1 a write in flight is forwarded to a matching read port in the
// same cycle; with ZERO_REG=1 address 0 is never written nor forwarded.
module int_reg_file64
  import alu_pkg::*;
#(
  parameter int DW       = DATA_W,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              W_En,
  input  logic [ADDR_W-1:0] W_Addr,
  input  logic [DW-1:0]     WR,
  input  logic [ADDR_W-1:0] R_Addr,
  input  logic [ADDR_W-1:0] S_Addr,
  output logic [DW-1:0]     R,
  output logic [DW-1:0]     S,
  input  logic              Flag_Ld,
  input  logic              N_in,
  input  logic              Z_in,
  input  logic              C_in,
  input  logic              V_in,
  output logic              N,
  output logic              Z,
  output logic              C,
  output logic              V,
  output logic              Wr_Zero_Err
);

  localparam bit ZERO_EN = (ZERO_REG != 0);
  localparam bit BYP_EN  = (BYPASS != 0);

  logic [DW-1:0] r_regs [NUM_REGS];
  logic          r_wr_zero_err;

  logic          w_wr_zero;
  logic          w_wr_ok;
  logic          w_byp_r;
  logic          w_byp_s;
  logic          w_r_zero;
  logic          w_s_zero;
  logic [3:0]    w_flags_in;
  logic [3:0]    w_flags_q;

  assign w_wr_zero = ZERO_EN && (W_Addr == '0);
  assign w_wr_ok   = W_En && !w_wr_zero;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_regs[W_Addr] <= WR;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_zero_err <= 1'b0;
    end else if (W_En && w_wr_zero) begin
      r_wr_zero_err <= 1'b1;
    end
  end

  // Forwarding uses w_wr_ok so a blocked write (register 0) never leaks to
  // the read ports; reset_n gates it because no write happens during reset.
  assign w_byp_r  = BYP_EN && reset_n && w_wr_ok && (W_Addr == R_Addr);
  assign w_byp_s  = BYP_EN && reset_n && w_wr_ok && (W_Addr == S_Addr);
  assign w_r_zero = ZERO_EN && (R_Addr == '0);
  assign w_s_zero = ZERO_EN && (S_Addr == '0);

  always_comb begin
    R = r_regs[R_Addr];
    if (w_r_zero) begin
      R = '0;
    end else if (w_byp_r) begin
      R = WR;
    end
  end

  always_comb begin
    S = r_regs[S_Addr];
    if (w_s_zero) begin
      S = '0;
    end else if (w_byp_s) begin
      S = WR;
    end
  end

  always_comb begin
    w_flags_in         = '0;
    w_flags_in[FLAG_N] = N_in;
    w_flags_in[FLAG_Z] = Z_in;
    w_flags_in[FLAG_C] = C_in;
    w_flags_in[FLAG_V] = V_in;
  end

  status_flag_reg #(.W(4)) u_status (
    .clk   (clk),
    .rst_n (reset_n),
    .i_ld  (Flag_Ld),
    .i_d   (w_flags_in),
    .o_q   (w_flags_q)
  );

  assign N           = w_flags_q[FLAG_N];
  assign Z           = w_flags_q[FLAG_Z];
  assign C           = w_flags_q[FLAG_C];
  assign V           = w_flags_q[FLAG_V];
  assign Wr_Zero_Err = r_wr_zero_err;

endmodule

// File: tb/tb_int_reg_file64.sv
module tb_int_reg_file64;

  logic        clk;
  logic        reset_n;
  logic        W_En;
  logic [4:0]  W_Addr;
  logic [63:0] WR;
  logic [4:0]  R_Addr;
  logic [4:0]  S_Addr;
  logic        Flag_Ld;
  logic        N_in, Z_in, C_in, V_in;

  // dut_a: BYPASS=1, dut_b: BYPASS=0; both ZERO_REG=1, same stimulus
  logic [63:0] r_a, s_a, r_b, s_b;
  logic        n_a, z_a, c_a, v_a, err_a;
  logic        n_b, z_b, c_b, v_b, err_b;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model
  logic [63:0] mdl [32];
  logic [3:0]  m_flags;
  logic        m_err;

  int_reg_file64 #(.BYPASS(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .W_En(W_En), .W_Addr(W_Addr), .WR(WR),
    .R_Addr(R_Addr), .S_Addr(S_Addr), .R(r_a), .S(s_a),
    .Flag_Ld(Flag_Ld), .N_in(N_in), .Z_in(Z_in), .C_in(C_in), .V_in(V_in),
    .N(n_a), .Z(z_a), .C(c_a), .V(v_a), .Wr_Zero_Err(err_a)
  );

  int_reg_file64 #(.BYPASS(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .W_En(W_En), .W_Addr(W_Addr), .WR(WR),
    .R_Addr(R_Addr), .S_Addr(S_Addr), .R(r_b), .S(s_b),
    .Flag_Ld(Flag_Ld), .N_in(N_in), .Z_in(Z_in), .C_in(C_in), .V_in(V_in),
    .N(n_b), .Z(z_b), .C(c_b), .V(v_b), .Wr_Zero_Err(err_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    m_flags = '0;
    m_err   = 1'b0;
  endtask

  function automatic logic [63:0] exp_read(input logic [4:0] addr, input bit byp);
    if (addr == 0) return '0;
    if (byp && reset_n && W_En && W_Addr == addr) return WR;
    return mdl[addr];
  endfunction

  task automatic drive(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                       input logic [4:0] ra, input logic [4:0] sa,
                       input logic fl, input logic [3:0] f);
    W_En = we; W_Addr = wa; WR = wd; R_Addr = ra; S_Addr = sa;
    Flag_Ld = fl; {N_in, Z_in, C_in, V_in} = f;
  endtask

  task automatic check_reads(input string tag);
    #1;
    check({tag, "_R_byp"},   r_a, exp_read(R_Addr, 1'b1));
    check({tag, "_S_byp"},   s_a, exp_read(S_Addr, 1'b1));
    check({tag, "_R_nobyp"}, r_b, exp_read(R_Addr, 1'b0));
    check({tag, "_S_nobyp"}, s_b, exp_read(S_Addr, 1'b0));
  endtask

  task automatic check_status(input string tag);
    check({tag, "_flags_a"}, {60'd0, n_a, z_a, c_a, v_a}, {60'd0, m_flags});
    check({tag, "_flags_b"}, {60'd0, n_b, z_b, c_b, v_b}, {60'd0, m_flags});
    check({tag, "_err_a"},   {63'd0, err_a}, {63'd0, m_err});
    check({tag, "_err_b"},   {63'd0, err_b}, {63'd0, m_err});
  endtask

  // one clock edge: update the model from the spec rules, then check state
  task automatic step(input string tag);
    @(posedge clk);
    if (reset_n) begin
      if (W_En && W_Addr != 0) mdl[W_Addr] = WR;
      if (W_En && W_Addr == 0) m_err = 1'b1;
      if (Flag_Ld) m_flags = {N_in, Z_in, C_in, V_in};
    end
    #1;
    check_status(tag);
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 4'b0000);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // reset state: every address on both ports
    for (int i = 0; i < 32; i++) begin
      R_Addr = 5'(i);
      S_Addr = 5'(31 - i);
      check_reads("reset");
    end
    check_status("reset");

    // write then read
    drive(1, 5, 64'h0123_4567_89AB_CDEF, 6, 6, 0, 4'b0000);
    check_reads("wr5_same");
    step("wr5");
    drive(0, 0, 0, 5, 5, 0, 4'b0000);
    check_reads("rd5");
    check("rd5_const", r_a, 64'h0123_4567_89AB_CDEF);
    R_Addr = 6;
    check_reads("rd6");
    check("rd6_const", r_a, 64'h0);

    // bypass vs no bypass
    drive(1, 7, 64'hFFFF_FFFF_FFFF_FFFF, 7, 7, 0, 4'b0000);
    check_reads("byp7");
    check("byp7_a_const", r_a, 64'hFFFF_FFFF_FFFF_FFFF);
    check("byp7_b_const", r_b, 64'h0);
    step("byp7");
    drive(0, 0, 0, 7, 7, 0, 4'b0000);
    check_reads("after7");
    check("after7_b_const", r_b, 64'hFFFF_FFFF_FFFF_FFFF);

    // zero register
    drive(1, 0, 64'hDEAD_BEEF, 0, 0, 0, 4'b0000);
    check_reads("zero_wr");
    check("zero_byp_const", r_a, 64'h0);
    step("zero_wr");
    check("zero_err_const", {63'd0, err_a}, 64'd1);
    drive(0, 0, 0, 0, 0, 0, 4'b0000);
    for (int i = 0; i < 10; i++) begin
      check_reads("zero_hold");
      step("zero_hold");
    end

    // flags load and hold
    drive(0, 0, 0, 0, 0, 1, 4'b1011);
    step("flag_ld");
    check("flag_ld_const", {60'd0, n_a, z_a, c_a, v_a}, 64'hB);
    drive(0, 0, 0, 0, 0, 0, 4'b0100);
    repeat (3) step("flag_hold");
    check("flag_hold_const", {60'd0, n_a, z_a, c_a, v_a}, 64'hB);

    // asynchronous reset mid-operation
    drive(1, 3, 64'h5, 0, 0, 1, 4'b1111);
    step("pre_rst");
    drive(0, 0, 0, 3, 3, 0, 4'b0000);
    check_reads("pre_rst_rd");
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    check_reads("async_rst");
    check("async_rst_r3", r_a, 64'h0);
    check_status("async_rst");
    @(negedge clk);
    reset_n = 1'b1;
    drive(1, 3, 64'h9, 3, 3, 0, 4'b0000);
    check_reads("post_rst_wr");
    step("post_rst_wr");
    drive(0, 0, 0, 3, 3, 0, 4'b0000);
    check_reads("post_rst_rd");
    check("post_rst_r3", r_b, 64'h9);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [4:0] wa, ra, sa;
      wa = 5'($urandom_range(0, 31));
      ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      sa = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 1)), wa, {$urandom, $urandom}, ra, sa,
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      check_reads("rand");
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
